// File: rtl/rns503_509_reverse_converter.sv
// rns503_509_reverse_converter: sequential residue pair {mod 503, mod 509} to binary converter
module rns503_509_reverse_converter #(
    parameter int MOD_A  = 503,
    parameter int MOD_B  = 509,
    parameter int INV_AB = 424,
    parameter int RW     = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] r_a,
    input  logic [RW-1:0] r_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [17:0]   x,
    output logic          err
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] FIN  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [8:0]  INV = 9'(INV_AB);
    localparam logic [9:0]  MB10 = 10'(MOD_B);
    localparam logic [10:0] MB11 = 11'(MOD_B);
    localparam logic [9:0]  MA10 = 10'(MOD_A);

    logic [2:0]  state_q, state_d;
    logic [8:0]  ra_q, ra_d, rb_q, rb_d;
    logic        bad_q, bad_d;
    logic [9:0]  d_q, d_d;
    logic [8:0]  acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [17:0] x_q, x_d;
    logic        err_q, err_d;
    logic [10:0] dbl, dbl_m, add, add_m;
    logic [17:0] x_calc;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign x         = x_q;
    assign err       = err_q;

    // One modular double-and-add step of k = d * INV mod 509, and the final 503*k + r_a
    always_comb begin
        dbl    = {1'b0, acc_q, 1'b0};
        dbl_m  = dbl >= MB11 ? dbl - MB11 : dbl;
        add    = dbl_m + {1'b0, d_q};
        add_m  = add >= MB11 ? add - MB11 : add;
        x_calc = {acc_q, 9'b0} - {6'b0, acc_q, 3'b0} - {9'b0, acc_q} + {9'b0, ra_q};
    end

    // Next-state logic for the conversion sequence
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        bad_d   = bad_q;
        d_d     = d_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        x_d     = x_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                ra_d    = r_a;
                rb_d    = r_b;
                bad_d   = ({1'b0, r_a} >= MA10) | ({1'b0, r_b} >= MB10);
                state_d = SUB;
            end
            SUB: begin
                d_d     = rb_q >= ra_q ? {1'b0, rb_q} - {1'b0, ra_q}
                                       : {1'b0, rb_q} - {1'b0, ra_q} + MB10;
                acc_d   = 9'd0;
                idx_d   = 4'd8;
                state_d = MUL;
            end
            MUL: begin
                acc_d   = INV[idx_q] ? 9'(add_m) : 9'(dbl_m);
                idx_d   = idx_q - 4'd1;
                state_d = idx_q == 4'd0 ? FIN : MUL;
            end
            FIN: begin
                x_d     = bad_q ? 18'd0 : x_calc;
                err_d   = bad_q;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            bad_q   <= 1'b0;
            d_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            bad_q   <= bad_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_rns503_509_reverse_converter.sv
// tb_rns503_509_reverse_converter: vector table, corner sequences and random CRT sweep
module tb_rns503_509_reverse_converter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  r_a = '0;
    logic [8:0]  r_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] x;
    logic        err;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [8:0]  a;
        logic [8:0]  b;
        logic [17:0] ex;
        logic        ee;
    } vec_t;

    rns503_509_reverse_converter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r_a(r_a), .r_b(r_b), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic run(input logic [8:0] a, input logic [8:0] b,
                       output logic [17:0] xo, output logic eo, output int lat);
        @(negedge clk);
        chk("in_ready_before", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        r_a = a;
        r_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        xo = x;
        eo = err;
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_accept", {31'b0, in_ready}, 1);
        chk("out_valid_after_accept", {31'b0, out_valid}, 0);
    endtask

    initial begin
        vec_t v[8];
        logic [17:0] xo, xh;
        logic eo;
        int lat, seen;
        int unsigned xr;
        v[0] = '{9'd0,   9'd0,   18'd0,      1'b0};
        v[1] = '{9'd497, 9'd491, 18'd1000,   1'b0};
        v[2] = '{9'd273, 9'd129, 18'd12345,  1'b0};
        v[3] = '{9'd502, 9'd508, 18'd256026, 1'b0};
        v[4] = '{9'd5,   9'd5,   18'd5,      1'b0};
        v[5] = '{9'd503, 9'd0,   18'd0,      1'b1};
        v[6] = '{9'd0,   9'd511, 18'd0,      1'b1};
        v[7] = '{9'd1,   9'd1,   18'd1,      1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 1);
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_x", {14'b0, x}, 0);
        chk("reset_err", {31'b0, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run(v[i].a, v[i].b, xo, eo, lat);
            chk($sformatf("vec%0d_x", i), {14'b0, xo}, {14'b0, v[i].ex});
            chk($sformatf("vec%0d_err", i), {31'b0, eo}, {31'b0, v[i].ee});
            chk($sformatf("vec%0d_latency", i), lat, 11);
            accept();
        end

        // Load a valid result, then reset mid-multiply: nothing may come out
        @(negedge clk);
        in_valid = 1'b1;
        r_a = 9'd100;
        r_b = 9'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_in_ready", {31'b0, in_ready}, 1);
        chk("midreset_out_valid", {31'b0, out_valid}, 0);
        chk("midreset_x", {14'b0, x}, 0);
        chk("midreset_err", {31'b0, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midreset_no_spurious", seen, 0);

        // Back-pressure with ignored input while busy
        run(9'd273, 9'd129, xo, eo, lat);
        chk("bp_x", {14'b0, xo}, 12345);
        xh = xo;
        in_valid = 1'b1;
        r_a = 9'd7;
        r_b = 9'd9;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (x !== xh || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        in_valid = 1'b0;
        chk("bp_stall_stable", seen, 0);
        accept();
        chk("bp_x_retained", {14'b0, x}, 12345);
        run(9'd497, 9'd491, xo, eo, lat);
        chk("bp_next_x", {14'b0, xo}, 1000);
        chk("bp_next_latency", lat, 11);
        accept();

        // Random sweep: residues derived from a random integer must map back to it
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            xr = $urandom_range(0, 256026);
            run(9'(xr % 503), 9'(xr % 509), xo, eo, lat);
            if (xo !== 18'(xr) || eo !== 1'b0 || lat != 11) begin
                seen++;
                if (seen <= 5)
                    $display("FAIL rand X=%0d got x=%0d err=%0b lat=%0d", xr, xo, eo, lat);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk("random_sweep_bad_count", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
